mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port 256×16 data/instruction RAM and the memory-mapped I/O (LEDs, switches) between the CPU's instruction-fetch port and its load/store port. It sits between the CPU and the RAM in the top-level wrapper, replacing the direct CPU-to-memory hookup. The data port normally wins, and a starvation guard guarantees fetch progress. One access is issued per cycle, with read data returned the following cycle.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits; range 1–15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `f_req`  in  1  fetch request (read only).
- `f_addr`  in  9  fetch address.
- `f_gnt`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  fetch read data valid.
- `f_rdata`  out  16  fetch read data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  9  data address.
- `d_wdata`  in  16  write data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data read data valid; never asserted for writes.
- `d_rdata`  out  16  data read data.
- `mem_addr`  out  8  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_din`  out  16  RAM write data.
- `mem_dout`  in  16  RAM read data; synchronous, valid one cycle after the address.
- `sw`  in  8  switch inputs.
- `led`  out  8  LED register.

## Operation
- Handshake: a request is accepted in the cycle where req=1 and gnt=1.
  - The requester holds addr, we and wdata stable until accepted.
  - req still high in the cycle after the grant is a new request.
- Grants are combinational from the current req inputs and registered arbiter state; at most one grant per cycle.
- Arbitration when both req are high:
  - data wins unless `starve_cnt == STARVE_LIMIT`; then fetch wins.
  - Only one requester high: that requester wins.
- `starve_cnt` (4 bits):
  - increments on each data grant while `f_req` is high;
  - clears on any fetch grant, or in any cycle with `f_req` low;
  - saturates at STARVE_LIMIT.
- Address decode (9-bit `A` from the winning port):
  - `A[8]==0`: RAM. `mem_addr=A[7:0]`. `mem_we = d_gnt & d_we`. `mem_din = d_wdata`.
  - `A==9'h100`: LED. A write loads `led <= d_wdata[7:0]`; RAM is not written. A read returns `{8'h00, led}`.
  - `A==9'h140`: switches. A read returns `{8'h00, sw}` sampled in the grant cycle. Writes are ignored.
  - Any other `A[8]==1`: reads return 16'h0000; writes are ignored.
- Read response: in the cycle after a read grant, the granted port's rvalid=1 for exactly one cycle.
  - rdata = `mem_dout` for RAM, or the registered I/O value for I/O.
  - rdata is don't-care when rvalid=0; the bench checks it only under rvalid.
- No grant: `mem_we=0`; `mem_addr` holds its last value; no RAM side effect.

## Timing
- Reset values: `f_rvalid=0`, `d_rvalid=0`, `led=8'h00`, `starve_cnt=0`, response-source/port registers cleared.
- While `reset=1`, `f_gnt=d_gnt=0` and `mem_we=0`.
- Reset asserted in the cycle after a read grant squashes that response: rvalid stays 0.
- Read latency: grant at cycle t, rvalid and rdata at cycle t+1. Write completes at the edge ending cycle t.
- Throughput: one grant per cycle. A read granted at t+1 overlaps the t response; its rvalid comes at t+2.
- Same-address write then read on consecutive cycles: the read returns the new value, because the RAM write commits at the edge ending t.
- `sw` is not synchronised here; the top level synchronises it.

## Structure
- Package `mem_map_pkg`:
  - `LED_ADDR = 9'h100`, `SW_ADDR = 9'h140`;
  - enum `resp_src_t {SRC_RAM, SRC_IO}`;
  - enum `port_t {PORT_F, PORT_D}`.
- Sub-module `mem_io_regs`: LED register plus registered I/O read mux. Inputs: decoded address, write strobe, `sw`. Output: the I/O read value.
- Top of block holds the arbitration logic, `starve_cnt`, and the response pipeline register (valid, port, source).

## Test plan
- Reset: assert `reset` for 2 cycles with both req high → no gnt, `led=0`, both rvalid 0.
- Fetch only: `f_req`, `f_addr=9'h010`, RAM[0x10]=16'hA5A5 → `f_gnt` at t, `f_rvalid=1` and `f_rdata=16'hA5A5` at t+1.
- Data write/read: write 16'hFFE9 to 9'h019, then read 9'h019 → RAM[25]=16'hFFE9; `d_rdata=16'hFFE9` one cycle after the read grant.
- I/O: write 16'h00C3 to 9'h100 → `led=8'hC3`, RAM unchanged; `sw=8'h5A`, read 9'h140 → `d_rdata=16'h005A`; read 9'h1FF → 16'h0000.
- Starvation: `d_req` and `f_req` held high for 12 cycles → pattern D,D,D,D,F repeating (STARVE_LIMIT=4); `mem_we` never set by fetch.
- Reset mid-read: data read granted at t, `reset=1` at t+1 → `d_rvalid=0` at t+1 and after.

Source files
------------

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map and shared types for the fetch/data memory arbiter
package mem_map_pkg;

   localparam logic [8:0] LED_ADDR = 9'h100;
   localparam logic [8:0] SW_ADDR  = 9'h140;

   typedef enum logic {SRC_RAM, SRC_IO} resp_src_t;
   typedef enum logic {PORT_F, PORT_D} port_t;

   function automatic logic is_ram(input logic [8:0] addr);
      return !addr[8];
   endfunction

endpackage

// File: rtl/mem_io_regs.sv
// rtl/mem_io_regs.sv - LED register and registered I/O read mux
module mem_io_regs
   import mem_map_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  addr,
   input  logic        wr_en,
   input  logic [7:0]  wdata,
   input  logic [7:0]  sw,
   output logic [7:0]  led,
   output logic [15:0] io_rdata
);

   logic [7:0]  led_q, led_d;
   logic [15:0] io_rdata_q, io_rdata_d;

   // The read value is captured every cycle; the top only consumes it after an I/O read grant.
   always_comb begin
      led_d      = led_q;
      io_rdata_d = 16'h0000;
      if (wr_en && addr == LED_ADDR) begin
         led_d = wdata;
      end
      if (addr == LED_ADDR) begin
         io_rdata_d = {8'h00, led_q};
      end else if (addr == SW_ADDR) begin
         io_rdata_d = {8'h00, sw};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q      <= 8'h00;
         io_rdata_q <= 16'h0000;
      end else begin
         led_q      <= led_d;
         io_rdata_q <= io_rdata_d;
      end
   end

   assign led      = led_q;
   assign io_rdata = io_rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared RAM and memory-mapped I/O
module mem_arbiter
   import mem_map_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [8:0]  f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [15:0] f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [8:0]  d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [15:0] d_rdata,
   output logic [7:0]  mem_addr,
   output logic        mem_we,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout,
   input  logic [7:0]  sw,
   output logic [7:0]  led
);

   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [7:0]  mem_addr_q, mem_addr_d;
   logic        rvalid_q, rvalid_d;
   port_t       port_q, port_d;
   resp_src_t   src_q, src_d;
   logic        starve_hit;
   logic [8:0]  sel_addr;
   logic        any_gnt;
   logic [15:0] io_rdata;
   logic [15:0] rdata;

   assign starve_hit = (starve_cnt_q == 4'(STARVE_LIMIT));

   // Data normally wins; fetch takes the slot once the data port has used up its allowance.
   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (f_req && (!d_req || starve_hit)) begin
            f_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end
      end
   end

   assign sel_addr = f_gnt ? f_addr : d_addr;
   assign any_gnt  = f_gnt | d_gnt;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!f_req || f_gnt) begin
         starve_cnt_d = 4'd0;
      end else if (d_gnt && !starve_hit) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
      mem_addr_d = any_gnt ? sel_addr[7:0] : mem_addr_q;
      rvalid_d   = f_gnt | (d_gnt & ~d_we);
      port_d     = f_gnt ? PORT_F : PORT_D;
      src_d      = is_ram(sel_addr) ? SRC_RAM : SRC_IO;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= 4'd0;
         mem_addr_q   <= 8'h00;
         rvalid_q     <= 1'b0;
         port_q       <= PORT_F;
         src_q        <= SRC_RAM;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         mem_addr_q   <= mem_addr_d;
         rvalid_q     <= rvalid_d;
         port_q       <= port_d;
         src_q        <= src_d;
      end
   end

   assign mem_addr = mem_addr_d;
   assign mem_we   = d_gnt & d_we & is_ram(d_addr);
   assign mem_din  = d_wdata;

   mem_io_regs u_io (
      .clk      (clk),
      .reset    (reset),
      .addr     (sel_addr),
      .wr_en    (d_gnt & d_we),
      .wdata    (d_wdata[7:0]),
      .sw       (sw),
      .led      (led),
      .io_rdata (io_rdata)
   );

   // Gating with reset squashes a response whose grant happened just before reset rose.
   assign rdata    = (src_q == SRC_RAM) ? mem_dout : io_rdata;
   assign f_rvalid = rvalid_q & ~reset & (port_q == PORT_F);
   assign d_rvalid = rvalid_q & ~reset & (port_q == PORT_D);
   assign f_rdata  = rdata;
   assign d_rdata  = rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural reference model
module tb_mem_arbiter;

   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_req, d_req, d_we;
   logic [8:0]  f_addr, d_addr;
   logic [15:0] d_wdata;
   logic        f_gnt, f_rvalid, d_gnt, d_rvalid;
   logic [15:0] f_rdata, d_rdata;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_din;
   logic [15:0] mem_dout;
   logic [7:0]  sw, led;

   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [15:0] ld_data;
   logic [15:0] ram [256];

   logic [15:0] ref_ram [256];
   logic [7:0]  ref_led;
   int          m_starve;
   logic        pend_v;
   logic        pend_port;
   logic [15:0] pend_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
      .sw(sw), .led(led)
   );

   always @(posedge clk) begin
      if (ld_en) ram[ld_addr] <= ld_data;
      else if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_read(input logic [8:0] a, input logic [7:0] swv);
      if (!a[8]) return ref_ram[a[7:0]];
      if (a == 9'h100) return {8'h00, ref_led};
      if (a == 9'h140) return {8'h00, swv};
      return 16'h0000;
   endfunction

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         #3;
         chk("rst_f_gnt", f_gnt, 0);
         chk("rst_d_gnt", d_gnt, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_f_rvalid", f_rvalid, 0);
         chk("rst_d_rvalid", d_rvalid, 0);
         @(posedge clk); #1;
         chk("rst_led", led, 0);
      end
      reset = 1'b0;
      pend_v = 1'b0;
      m_starve = 0;
      ref_led = 8'h00;
   endtask

   task automatic do_cycle(input logic fr, input logic [8:0] fa, input logic dr, input logic dw,
                           input logic [8:0] da, input logic [15:0] dwd, input logic [7:0] swv,
                           output logic exp_f, output logic exp_d, output logic obs_f);
      logic [8:0] a;
      f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; sw = swv;
      #3;
      chk("f_rvalid", f_rvalid, pend_v && !pend_port);
      chk("d_rvalid", d_rvalid, pend_v && pend_port);
      if (pend_v) chk(pend_port ? "d_rdata" : "f_rdata", pend_port ? d_rdata : f_rdata, pend_data);
      exp_f = fr && (!dr || m_starve == STARVE_LIMIT);
      exp_d = dr && !exp_f;
      a = exp_f ? fa : da;
      chk("f_gnt", f_gnt, exp_f);
      chk("d_gnt", d_gnt, exp_d);
      chk("mem_we", mem_we, exp_d && dw && !da[8]);
      if ((exp_f || exp_d) && !a[8]) chk("mem_addr", mem_addr, a[7:0]);
      obs_f = f_gnt;
      pend_v = exp_f || (exp_d && !dw);
      pend_port = exp_d;
      pend_data = model_read(a, swv);
      if (exp_d && dw) begin
         if (!da[8]) ref_ram[da[7:0]] = dwd;
         else if (da == 9'h100) ref_led = dwd[7:0];
      end
      if (!fr || exp_f) m_starve = 0;
      else if (exp_d && m_starve < STARVE_LIMIT) m_starve++;
      @(posedge clk); #1;
      chk("led", led, ref_led);
   endtask

   function automatic logic [8:0] rand_addr();
      case ($urandom % 8)
         0: return 9'h100;
         1: return 9'h140;
         2: return {1'b1, 8'($urandom)};
         default: return {1'b0, 8'($urandom_range(0, 31))};
      endcase
   endfunction

   initial begin
      logic ef, ed, of;
      logic [15:0] r0;
      logic fp_v, dp_v, dp_we;
      logic [8:0] fp_a, dp_a;
      logic [15:0] dp_wd;
      logic [7:0] swv;

      reset = 1'b1; f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0; sw = 0;
      ld_en = 1'b1; ld_addr = 0; ld_data = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) begin
         ld_addr = 8'(i);
         ld_data = (i == 16) ? 16'hA5A5 : 16'($urandom);
         ref_ram[i] = ld_data;
         @(posedge clk); #1;
      end
      ld_en = 1'b0;

      f_req = 1; d_req = 1; d_we = 0;
      do_reset(2);

      do_cycle(1, 9'h010, 0, 0, 0, 0, 0, ef, ed, of);
      do_cycle(0, 0, 0, 0, 0, 0, 0, ef, ed, of);

      do_cycle(0, 0, 1, 1, 9'h019, 16'hFFE9, 0, ef, ed, of);
      do_cycle(0, 0, 1, 0, 9'h019, 0, 0, ef, ed, of);
      do_cycle(0, 0, 0, 0, 0, 0, 0, ef, ed, of);
      chk("ram25", ram[25], 16'hFFE9);

      r0 = ram[0];
      do_cycle(0, 0, 1, 1, 9'h100, 16'h00C3, 0, ef, ed, of);
      chk("led_c3", led, 8'hC3);
      chk("ram0_kept", ram[0], r0);
      do_cycle(0, 0, 1, 0, 9'h140, 0, 8'h5A, ef, ed, of);
      do_cycle(0, 0, 1, 0, 9'h1FF, 0, 8'h33, ef, ed, of);
      do_cycle(0, 0, 0, 0, 0, 0, 8'h33, ef, ed, of);

      for (int i = 0; i < 12; i++) begin
         do_cycle(1, 9'h020, 1, 1, {1'b0, 8'(8'h40 + i)}, 16'($urandom), 0, ef, ed, of);
         chk("starve_pattern", of, (i % 5) == 4);
      end
      do_cycle(0, 0, 0, 0, 0, 0, 0, ef, ed, of);

      do_cycle(0, 0, 1, 0, 9'h019, 0, 0, ef, ed, of);
      do_reset(2);

      fp_v = 0; dp_v = 0; fp_a = 0; dp_a = 0; dp_we = 0; dp_wd = 0;
      for (int i = 0; i < 400; i++) begin
         if (!fp_v && ($urandom % 3 != 0)) begin
            fp_v = 1; fp_a = rand_addr();
         end
         if (!dp_v && ($urandom % 4 != 0)) begin
            dp_v = 1; dp_a = rand_addr(); dp_we = 1'($urandom); dp_wd = 16'($urandom);
         end
         swv = 8'($urandom);
         do_cycle(fp_v, fp_a, dp_v, dp_we, dp_a, dp_wd, swv, ef, ed, of);
         if (ef) fp_v = 0;
         if (ed) dp_v = 0;
      end
      do_cycle(0, 0, 0, 0, 0, 0, 0, ef, ed, of);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
